// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    // Write-address / data mux select encodings. 2'b11 is never driven.
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    // Default starvation threshold and counter width (2**CNT_W must exceed MAX_WAIT).
    localparam int MAX_WAIT_DEF = 4;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/regfile_wb_arbiter_wait_counter.sv
// Saturating per-source wait counter with freeze/clear control and an urgent flag.
module wb_wait_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic grant,
    input  logic hold,
    output logic urgent
);

    logic [CNT_W-1:0] cnt;

    // Freeze under hold; clear on grant or idle; otherwise count denied cycles up to MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (grant || !valid) begin
            cnt <= '0;
        end else if (cnt < CNT_W'(MAX_WAIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Urgency is raw counter state; the top qualifies it with the live valid.
    assign urgent = (cnt >= CNT_W'(MAX_WAIT));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port arbiter: ALU (rd), load (rt) and link (r31).
// Grants are combinational; mux select, write enable and starvation pulse are
// registered so the write lands one cycle after the handshake.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_valid,
    output logic       alu_ready,
    input  logic       mem_valid,
    output logic       mem_ready,
    input  logic       link_valid,
    output logic       link_ready,
    input  logic       wb_hold,
    output logic [1:0] wb_sel,
    output logic       rf_we,
    output logic       starve_evt
);

    logic alu_urgent;
    logic link_urgent;
    logic urgent_grant;

    // MEM has no counter: it can only be bypassed by one urgent grant at a time.
    wb_wait_counter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_alu_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (alu_valid),
        .grant  (alu_ready),
        .hold   (wb_hold),
        .urgent (alu_urgent)
    );

    wb_wait_counter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_link_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (link_valid),
        .grant  (link_ready),
        .hold   (wb_hold),
        .urgent (link_urgent)
    );

    // Priority encode: urgent ALU > urgent LINK > MEM > LINK > ALU; nothing in reset or hold.
    always_comb begin
        alu_ready    = 1'b0;
        mem_ready    = 1'b0;
        link_ready   = 1'b0;
        urgent_grant = 1'b0;
        if (rst_n && !wb_hold) begin
            if (alu_valid && alu_urgent) begin
                alu_ready    = 1'b1;
                urgent_grant = 1'b1;
            end else if (link_valid && link_urgent) begin
                link_ready   = 1'b1;
                urgent_grant = 1'b1;
            end else if (mem_valid) begin
                mem_ready    = 1'b1;
            end else if (link_valid) begin
                link_ready   = 1'b1;
            end else if (alu_valid) begin
                alu_ready    = 1'b1;
            end
        end
    end

    // Register the winning source into the mux select / write enable; park on ALU when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_sel     <= WB_SEL_ALU;
            rf_we      <= 1'b0;
            starve_evt <= 1'b0;
        end else begin
            rf_we      <= alu_ready | mem_ready | link_ready;
            starve_evt <= urgent_grant;
            if (mem_ready)       wb_sel <= WB_SEL_MEM;
            else if (link_ready) wb_sel <= WB_SEL_LINK;
            else                 wb_sel <= WB_SEL_ALU;
        end
    end

endmodule
